// File: rtl/ds_is_pipe_skid.sv
// ds_is_pipe_skid: dispatch-to-issue pipeline register with valid/ready handshake, skid buffer, empty-group drop and issued-lane counter
module ds_is_pipe_skid #(
  parameter int LANES      = 2,
  parameter int ALUOP_W    = 9,
  parameter int AREG_W     = 5,
  parameter int PREG_W     = 6,
  parameter int CNT_W      = 32,
  parameter int DROP_EMPTY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      ds_valid,
  output logic                      ds_ready,
  input  logic [31:0]               ds_pc,
  input  logic [LANES-1:0]          ds_lane_valid,
  input  logic [LANES*ALUOP_W-1:0]  ds_aluop,
  input  logic [LANES*AREG_W-1:0]   ds_rdst,
  input  logic [LANES*PREG_W-1:0]   ds_rsrc1,
  input  logic [LANES*PREG_W-1:0]   ds_rsrc2,
  input  logic [LANES*PREG_W-1:0]   ds_phydst,
  input  logic [LANES*32-1:0]       ds_imm,
  output logic                      is_valid,
  input  logic                      is_ready,
  output logic [LANES-1:0]          is_lane_valid,
  output logic [LANES*ALUOP_W-1:0]  is_aluop,
  output logic [LANES*AREG_W-1:0]   is_rdst,
  output logic [LANES*PREG_W-1:0]   is_rsrc1,
  output logic [LANES*PREG_W-1:0]   is_rsrc2,
  output logic [LANES*PREG_W-1:0]   is_phydst,
  output logic [LANES*32-1:0]       is_imm,
  output logic [LANES*32-1:0]       is_pc,
  output logic [CNT_W-1:0]          issued_cnt
);
  localparam int PW = LANES * (1 + ALUOP_W + AREG_W + 3 * PREG_W + 64);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_n;
  logic [PW-1:0] main_q, skid_q, main_n, skid_n, in_e;
  logic [LANES*32-1:0] pcs;
  logic [CNT_W-1:0] pop;
  logic acc, keep, iss;
  for (genvar i = 0; i < LANES; i++) begin : g_pc
    assign pcs[i*32 +: 32] = ds_pc + 32'(4 * i);
  end
  assign in_e = {ds_lane_valid, ds_aluop, ds_rdst, ds_rsrc1, ds_rsrc2, ds_phydst, ds_imm, pcs};
  assign {is_lane_valid, is_aluop, is_rdst, is_rsrc1, is_rsrc2, is_phydst, is_imm, is_pc} = main_q;
  assign is_valid = state != EMPTY;
  assign iss = is_valid & is_ready;
  assign acc = ds_valid & ds_ready;
  assign keep = acc & ((DROP_EMPTY == 0) | (|ds_lane_valid));
  always_comb begin
    state_n = state == EMPTY ? (keep ? ONE : EMPTY)
            : state == ONE   ? (keep & !iss ? TWO : !keep & iss ? EMPTY : ONE)
            : (iss ? ONE : TWO);
    main_n = (state == TWO & iss) ? skid_q : (keep & (state == EMPTY | iss)) ? in_e : main_q;
    skid_n = (state == ONE & keep & !iss) ? in_e : skid_q;
    pop = '0;
    for (int k = 0; k < LANES; k++) pop = pop + CNT_W'(is_lane_valid[k]);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      ds_ready   <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
      issued_cnt <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      ds_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= state_n;
      ds_ready <= state_n != TWO;
      main_q   <= main_n;
      skid_q   <= skid_n;
      if (iss) issued_cnt <= issued_cnt + pop;
    end
  end
endmodule

// File: tb/tb_ds_is_pipe_skid.sv
// tb_ds_is_pipe_skid: scoreboard bench with queue reference model for ds_is_pipe_skid
module tb_ds_is_pipe_skid;
  localparam int L = 2;
  logic clk = 0, rst = 0, flush = 0, ds_valid = 0, is_ready = 0;
  logic [31:0] ds_pc = 0;
  logic [L-1:0] ds_lane_valid = 0;
  logic [L*9-1:0] ds_aluop = 0;
  logic [L*5-1:0] ds_rdst = 0;
  logic [L*6-1:0] ds_rsrc1 = 0, ds_rsrc2 = 0, ds_phydst = 0;
  logic [L*32-1:0] ds_imm = 0;
  logic ds_ready, is_valid;
  logic [L-1:0] is_lane_valid;
  logic [L*9-1:0] is_aluop;
  logic [L*5-1:0] is_rdst;
  logic [L*6-1:0] is_rsrc1, is_rsrc2, is_phydst;
  logic [L*32-1:0] is_imm, is_pc;
  logic [31:0] issued_cnt;
  logic d0_valid = 0, d0_is_ready = 0, d0_ready, d0_is_valid;
  logic [31:0] d0_pc = 0;
  logic [L-1:0] d0_lv = 0, d0_is_lane_valid;
  logic [L*9-1:0] d0_is_aluop;
  logic [L*5-1:0] d0_is_rdst;
  logic [L*6-1:0] d0_is_rsrc1, d0_is_rsrc2, d0_is_phydst;
  logic [L*32-1:0] d0_is_imm, d0_is_pc;
  logic [3:0] d0_cnt;
  typedef struct packed {
    logic [L-1:0] lv;
    logic [L*9-1:0] op;
    logic [L*5-1:0] rd;
    logic [L*6-1:0] s1, s2, pd;
    logic [L*32-1:0] imm, pc;
  } ent_t;
  ent_t q[$];
  ent_t act;
  logic [31:0] exp_cnt = 0, cb;
  bit rdy_m = 1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign act = {is_lane_valid, is_aluop, is_rdst, is_rsrc1, is_rsrc2, is_phydst, is_imm, is_pc};
  ds_is_pipe_skid dut (
    .clk(clk), .rst(rst), .flush(flush), .ds_valid(ds_valid), .ds_ready(ds_ready),
    .ds_pc(ds_pc), .ds_lane_valid(ds_lane_valid), .ds_aluop(ds_aluop), .ds_rdst(ds_rdst),
    .ds_rsrc1(ds_rsrc1), .ds_rsrc2(ds_rsrc2), .ds_phydst(ds_phydst), .ds_imm(ds_imm),
    .is_valid(is_valid), .is_ready(is_ready), .is_lane_valid(is_lane_valid), .is_aluop(is_aluop),
    .is_rdst(is_rdst), .is_rsrc1(is_rsrc1), .is_rsrc2(is_rsrc2), .is_phydst(is_phydst),
    .is_imm(is_imm), .is_pc(is_pc), .issued_cnt(issued_cnt)
  );
  ds_is_pipe_skid #(.DROP_EMPTY(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .flush(1'b0), .ds_valid(d0_valid), .ds_ready(d0_ready),
    .ds_pc(d0_pc), .ds_lane_valid(d0_lv), .ds_aluop(ds_aluop), .ds_rdst(ds_rdst),
    .ds_rsrc1(ds_rsrc1), .ds_rsrc2(ds_rsrc2), .ds_phydst(ds_phydst), .ds_imm(ds_imm),
    .is_valid(d0_is_valid), .is_ready(d0_is_ready), .is_lane_valid(d0_is_lane_valid),
    .is_aluop(d0_is_aluop), .is_rdst(d0_is_rdst), .is_rsrc1(d0_is_rsrc1), .is_rsrc2(d0_is_rsrc2),
    .is_phydst(d0_is_phydst), .is_imm(d0_is_imm), .is_pc(d0_is_pc), .issued_cnt(d0_cnt)
  );
  task automatic chk(string n, logic [255:0] a, logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic ent_t mk();
    ent_t e;
    e.lv = ds_lane_valid;
    e.op = ds_aluop;
    e.rd = ds_rdst;
    e.s1 = ds_rsrc1;
    e.s2 = ds_rsrc2;
    e.pd = ds_phydst;
    e.imm = ds_imm;
    for (int i = 0; i < L; i++) e.pc[i*32 +: 32] = ds_pc + 32'(4 * i);
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      chk("ds_ready", 256'(ds_ready), 256'(q.size() < 2));
      chk("is_valid", 256'(is_valid), 256'(q.size() != 0));
      if (q.size() != 0) chk("payload", 256'(act), 256'(q[0]));
      chk("issued_cnt", 256'(issued_cnt), 256'(exp_cnt));
      rdy_m = q.size() < 2;
      if (!flush && q.size() != 0 && is_ready) begin
        exp_cnt += 32'($countones(q[0].lv));
        void'(q.pop_front());
      end
    end
  end
  task automatic step(logic v, logic [31:0] pc, logic [1:0] lv, logic rdy, logic fl);
    ds_valid = v;
    ds_pc = pc;
    ds_lane_valid = lv;
    is_ready = rdy;
    flush = fl;
    ds_aluop = 18'($urandom);
    ds_rdst = 10'($urandom);
    ds_rsrc1 = 12'($urandom);
    ds_rsrc2 = 12'($urandom);
    ds_phydst = 12'($urandom);
    ds_imm = {$urandom, $urandom};
    @(posedge clk);
    if (!rst) begin
      q.delete();
      exp_cnt = 0;
    end else if (flush) q.delete();
    else if (ds_valid && rdy_m && ds_lane_valid != 0) q.push_back(mk());
    #1;
  endtask
  initial begin
    rst = 0;
    repeat (2) step(0, 0, 0, 0, 0);
    rst = 1;
    chk("rst_is_valid", 256'(is_valid), 256'(0));
    chk("rst_ds_ready", 256'(ds_ready), 256'(1));
    chk("rst_cnt", 256'(issued_cnt), 256'(0));
    chk("rst_payload", 256'(act), 256'(0));
    step(1, 32'h1000, 2'b11, 1, 0);
    chk("single_valid", 256'(is_valid), 256'(1));
    chk("single_pc", 256'(is_pc), 256'({32'h1004, 32'h1000}));
    step(0, 0, 0, 1, 0);
    chk("single_cnt", 256'(issued_cnt), 256'(2));
    step(1, 32'h2000, 2'b11, 0, 0);
    step(1, 32'h3000, 2'b10, 0, 0);
    chk("bp_ready_low", 256'(ds_ready), 256'(0));
    chk("bp_main_a", 256'(is_pc[31:0]), 256'(32'h2000));
    step(1, 32'h4000, 2'b01, 0, 0);
    chk("bp_hold_a", 256'(is_pc[31:0]), 256'(32'h2000));
    step(1, 32'h4000, 2'b01, 1, 0);
    chk("bp_main_b", 256'(is_pc[31:0]), 256'(32'h3000));
    chk("bp_ready_up", 256'(ds_ready), 256'(1));
    step(1, 32'h4000, 2'b01, 1, 0);
    chk("bp_main_c", 256'(is_pc[31:0]), 256'(32'h4000));
    step(0, 0, 0, 1, 0);
    chk("bp_drained", 256'(is_valid), 256'(0));
    cb = exp_cnt;
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h8000 + 32'(8 * i), 2'b01, 1, 0);
      chk("stream_ready", 256'(ds_ready), 256'(1));
    end
    step(0, 0, 0, 1, 0);
    chk("stream_cnt", 256'(issued_cnt), 256'(cb + 32'd10));
    step(1, 32'h5000, 2'b11, 0, 0);
    step(1, 32'h5100, 2'b11, 0, 0);
    cb = exp_cnt;
    step(1, 32'h5200, 2'b11, 1, 1);
    chk("flush2_valid", 256'(is_valid), 256'(0));
    chk("flush2_ready", 256'(ds_ready), 256'(1));
    chk("flush2_payload", 256'(act), 256'(0));
    chk("flush2_cnt", 256'(issued_cnt), 256'(cb));
    step(1, 32'h5300, 2'b11, 0, 0);
    cb = exp_cnt;
    step(1, 32'h5400, 2'b11, 1, 1);
    chk("flush1_valid", 256'(is_valid), 256'(0));
    chk("flush1_cnt", 256'(issued_cnt), 256'(cb));
    step(1, 32'h6000, 2'b00, 1, 0);
    chk("drop_empty", 256'(is_valid), 256'(0));
    step(1, 32'hFFFF_FFFC, 2'b11, 1, 0);
    chk("pc_wrap", 256'(is_pc), 256'({32'h0, 32'hFFFF_FFFC}));
    step(1, 32'h7000, 2'b11, 0, 0);
    step(1, 32'h7100, 2'b11, 0, 0);
    rst = 0;
    step(0, 0, 0, 0, 0);
    rst = 1;
    chk("midrst_valid", 256'(is_valid), 256'(0));
    chk("midrst_cnt", 256'(issued_cnt), 256'(0));
    chk("midrst_ready", 256'(ds_ready), 256'(1));
    repeat (400)
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4) : $urandom,
           2'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("drain_valid", 256'(is_valid), 256'(0));
    d0_is_ready = 1;
    d0_valid = 1;
    d0_lv = 2'b00;
    d0_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    d0_valid = 0;
    chk("keep_empty_valid", 256'(d0_is_valid), 256'(1));
    chk("keep_empty_lv", 256'(d0_is_lane_valid), 256'(0));
    chk("d0_pc_wrap", 256'(d0_is_pc), 256'({32'h0, 32'hFFFF_FFFC}));
    @(posedge clk); #1;
    chk("keep_empty_cnt", 256'(d0_cnt), 256'(0));
    chk("keep_empty_gone", 256'(d0_is_valid), 256'(0));
    for (int i = 0; i < 9; i++) begin
      d0_valid = 1;
      d0_lv = i == 0 ? 2'b01 : 2'b11;
      d0_pc = 32'(8 * i);
      @(posedge clk); #1;
    end
    chk("cnt4_at15", 256'(d0_cnt), 256'(15));
    d0_valid = 0;
    @(posedge clk); #1;
    chk("cnt4_wrap", 256'(d0_cnt), 256'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ds_is_pipe_skid.md
Name: ds_is_pipe_skid

Overview:
- Parametrised successor to the 2-wide dispatch-to-issue pipeline register.
- Carries a LANES-wide dispatch group (ALU op, arch dst, physical sources and dst, immediate, per-lane PC) from the dispatch stage to the issue stage.
- Replaces the global Stall with a valid/ready handshake and a one-entry skid buffer, so the stage sustains full throughput without a combinational ready path.
- Adds empty-group dropping and an issued-instruction counter.

Parameters:
- LANES, 2, instructions per dispatch group (1..8).
- ALUOP_W, 9, ALU op width per lane.
- AREG_W, 5, architectural register index width.
- PREG_W, 6, physical register index width.
- CNT_W, 32, width of the issued-instruction counter.
- DROP_EMPTY, 1, when 1 an accepted group with all lane valids 0 is discarded and not stored.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low; rst=0 resets on the next rising edge.
- flush  in  1  synchronous pipeline flush, active-high.
- ds_valid  in  1  dispatch group offered.
- ds_ready  out  1  stage can accept; registered.
- ds_pc  in  32  PC of lane 0 of the group.
- ds_lane_valid  in  LANES  per-lane valid.
- ds_aluop  in  LANES*ALUOP_W  lane i at [i*ALUOP_W +: ALUOP_W]; all other bundles use the same packing.
- ds_rdst  in  LANES*AREG_W  architectural dst.
- ds_rsrc1, ds_rsrc2, ds_phydst  in  LANES*PREG_W each  physical sources and dst.
- ds_imm  in  LANES*32  immediates.
- is_valid  out  1  group presented to issue.
- is_ready  in  1  issue consumes the group.
- is_lane_valid, is_aluop, is_rdst, is_rsrc1, is_rsrc2, is_phydst, is_imm  out  same widths as ds_* counterparts.
- is_pc  out  LANES*32  per-lane PC.
- issued_cnt  out  CNT_W  running count of issued valid lanes.

Behaviour:
- Handshakes:
  - Accept = ds_valid & ds_ready.
  - Issue = is_valid & is_ready.
- Storage is two entries:
  - MAIN drives every is_* output.
  - SKID holds overflow.
- States and transitions:
  - EMPTY: accept → ONE (MAIN loaded).
  - ONE:
    - accept & issue → ONE (MAIN reloaded).
    - accept & !issue → TWO (SKID loaded).
    - !accept & issue → EMPTY.
    - otherwise hold.
  - TWO: issue → ONE (MAIN ← SKID); otherwise hold. No accept is possible in TWO.
- ds_ready = (state != TWO), registered.
- is_valid = (state != EMPTY).
- Zero-bubble: a group accepted at edge N is visible on is_* in cycle N+1. Back-to-back accept and issue gives one group per cycle.
- PC: on capture, lane i PC = ds_pc + 4*i, modulo 2^32 (wraps at 32'hFFFF_FFFC).
- DROP_EMPTY=1:
  - An accepted group with ds_lane_valid==0 is consumed but not stored; the state does not advance for it.
  - ds_ready is unaffected.
- DROP_EMPTY=0: empty groups are stored and issued normally.
- issued_cnt adds popcount(is_lane_valid) on each issue and wraps modulo 2^CNT_W.
- Payload fields hold value while the stage is stalled (is_valid & !is_ready).
- Flush (rst=1, flush=1):
  - state → EMPTY; all lane valids → 0; ds_ready → 1.
  - Payload is zeroed.
  - issued_cnt is not cleared.
  - Flush beats any same-cycle accept or issue: the accepted group is lost, and an issue in that cycle is not counted.
- Reset (rst=0):
  - Everything cleared: state EMPTY, is_valid=0, every is_* field 0, issued_cnt=0.
  - ds_ready=1 from the first cycle after reset.
  - Reset mid-operation discards both entries.
- Reset beats flush.

Test Plan:
- Reset then single group: LANES=2, ds_pc=32'h1000, lane_valid=2'b11, is_ready=1 → next cycle is_valid=1, is_pc={32'h1004,32'h1000}; issued_cnt=2 one cycle later.
- Backpressure:
  - Hold is_ready=0 and offer groups A, B, C → A in MAIN, B in SKID, ds_ready=0 after B, C not accepted.
  - Raise is_ready → A, B, then C issue on consecutive cycles, order preserved.
- Streaming: ds_valid=1 and is_ready=1 for 10 cycles, lane_valid=2'b01 → one group per cycle, issued_cnt=10, ds_ready never drops.
- Flush while in TWO with a same-cycle accept → next cycle is_valid=0, ds_ready=1, all is_* fields zero, issued_cnt unchanged.
- DROP_EMPTY=1, accept a lane_valid=0 group in EMPTY → is_valid stays 0. DROP_EMPTY=0, same stimulus → is_valid=1, lane_valid=0, issued_cnt +0.
- PC wrap: ds_pc=32'hFFFF_FFFC, LANES=2 → is_pc lane1=32'h0000_0000. CNT_W=4 counter at 15 plus 2 lanes issued → issued_cnt=1.
